ctrl_useq: RTL

- Parametrised, microcoded successor to the team's flat combinational control decoder.
- Takes an OPW-bit opcode over a valid/ready handshake and looks up a start address in a programmable dispatch table.
- Steps through a programmable micro-store, emitting one CW-bit control word per handshake until an end-flagged word, with a runaway watchdog.
- Sits between the instruction front end and the datapath; replaces fixed decode with multi-cycle, field-reprogrammable sequences.

---
 rtl/ctrl_useq.sv | 117 +++++++++++
 1 files changed

// File: rtl/ctrl_useq.sv
// Microcoded control sequencer: opcode -> dispatch table -> micro-store walk,
// one control word per handshake, terminated by an end flag or the watchdog.
module ctrl_useq #(
  parameter int OPW    = 7,
  parameter int CW     = 26,
  parameter int UAW    = 5,
  parameter int MAXRUN = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 op_valid,
  output logic                                 op_ready,
  input  logic [OPW-1:0]                       op,
  output logic                                 cw_valid,
  input  logic                                 cw_ready,
  output logic [CW-1:0]                        cw,
  output logic                                 cw_last,
  output logic                                 busy,
  output logic                                 err_runaway,
  input  logic                                 prog_en,
  input  logic                                 prog_sel,
  input  logic [((OPW > UAW) ? OPW : UAW)-1:0] prog_addr,
  input  logic [CW:0]                          prog_data,
  output logic                                 prog_err
);

  localparam int ODEPTH = 2 ** OPW;
  localparam int UDEPTH = 2 ** UAW;
  localparam int SW     = (MAXRUN > 2) ? $clog2(MAXRUN) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state, state_nxt;
  logic [UAW-1:0] disp   [ODEPTH];
  logic [CW:0]    ustore [UDEPTH];
  logic [UAW-1:0] upc;
  logic [SW-1:0]  stepcnt;
  logic [CW:0]    cur;
  logic           wdog;
  logic           accept;
  logic           hs;
  logic           prog_ok;

  assign cur = ustore[upc];

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    busy      = 1'b0;
    cw_valid  = 1'b0;
    cw        = '0;
    cw_last   = 1'b0;
    wdog      = (stepcnt == SW'(MAXRUN - 1));
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        cw_valid = 1'b1;
        cw       = cur[CW-1:0];
        cw_last  = cur[CW] | wdog;
        if (cw_ready && cw_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    hs      = 1'b0;
    prog_ok = 1'b0;
    accept  = op_valid & op_ready;
    hs      = cw_valid & cw_ready;
    // An opcode accept in the same cycle takes priority over a table write.
    prog_ok = prog_en & (state == IDLE) & ~accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upc         <= '0;
      stepcnt     <= '0;
      err_runaway <= 1'b0;
      prog_err    <= 1'b0;
    end else begin
      err_runaway <= hs & cw_last & ~cur[CW];
      prog_err    <= prog_en & ~prog_ok;
      if (accept) begin
        upc     <= disp[op];
        stepcnt <= '0;
      end else if (hs && !cw_last) begin
        upc     <= upc + 1'b1;
        stepcnt <= stepcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp   <= '{default: '0};
      ustore <= '{default: {1'b1, {CW{1'b0}}}};
    end else if (prog_ok) begin
      if (prog_sel) ustore[prog_addr[UAW-1:0]] <= prog_data;
      else          disp[prog_addr[OPW-1:0]]   <= prog_data[UAW-1:0];
    end
  end

endmodule
